// File: rtl/led_blinker_multi.sv
// Multi-channel LED driver: per-channel off / on / blink / one-shot with a
// runtime half-period and a global phase-realign input.
module led_blinker_multi #(
   parameter int unsigned CHANNELS     = 4,
   parameter int unsigned CNT_WIDTH    = 33,
   parameter int unsigned DEFAULT_HALF = 5000
) (
   input  logic                 CLOCK_50,
   input  logic                 reset,
   input  logic                 cfg_we,
   input  logic [3:0]           cfg_ch,
   input  logic [1:0]           cfg_mode,
   input  logic [CNT_WIDTH-1:0] cfg_half,
   input  logic                 sync,
   output logic [CHANNELS-1:0]  LED,
   output logic [CHANNELS-1:0]  LED_N,
   output logic [CHANNELS-1:0]  tick,
   output logic [CHANNELS-1:0]  busy
);

   typedef enum logic [1:0] {
      MODE_OFF     = 2'b00,
      MODE_ON      = 2'b01,
      MODE_BLINK   = 2'b10,
      MODE_ONESHOT = 2'b11
   } mode_t;

   mode_t                mode_q [CHANNELS];
   mode_t                mode_d [CHANNELS];
   logic [CNT_WIDTH-1:0] half_q [CHANNELS];
   logic [CNT_WIDTH-1:0] half_d [CHANNELS];
   logic [CNT_WIDTH-1:0] cnt_q  [CHANNELS];
   logic [CNT_WIDTH-1:0] cnt_d  [CHANNELS];
   logic [CHANNELS-1:0]  led_d;
   logic [CHANNELS-1:0]  tick_d;
   logic [CHANNELS-1:0]  busy_d;

   // Next-state per channel: write beats sync beats normal counting.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         mode_d[i] = mode_q[i];
         half_d[i] = half_q[i];
         cnt_d[i]  = cnt_q[i];
         led_d[i]  = LED[i];
         tick_d[i] = 1'b0;

         if (cfg_we && (cfg_ch == 4'(i))) begin
            mode_d[i] = mode_t'(cfg_mode);
            half_d[i] = cfg_half;
            cnt_d[i]  = '0;
            led_d[i]  = (mode_t'(cfg_mode) == MODE_ON) || (mode_t'(cfg_mode) == MODE_ONESHOT);
         end else if (sync && (mode_q[i] == MODE_BLINK)) begin
            cnt_d[i] = '0;
            led_d[i] = 1'b0;
         end else begin
            case (mode_q[i])
               MODE_BLINK: begin
                  if (cnt_q[i] == half_q[i]) begin
                     cnt_d[i]  = '0;
                     led_d[i]  = ~LED[i];
                     tick_d[i] = 1'b1;
                  end else begin
                     cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                  end
               end
               MODE_ONESHOT: begin
                  if (cnt_q[i] == half_q[i]) begin
                     cnt_d[i]  = '0;
                     led_d[i]  = 1'b0;
                     mode_d[i] = MODE_OFF;
                     tick_d[i] = 1'b1;
                  end else begin
                     cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                  end
               end
               default: cnt_d[i] = '0;
            endcase
         end

         busy_d[i] = (mode_d[i] == MODE_ONESHOT);
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            mode_q[i] <= MODE_OFF;
            half_q[i] <= CNT_WIDTH'(DEFAULT_HALF);
            cnt_q[i]  <= '0;
         end
         LED   <= '0;
         LED_N <= '1;
         tick  <= '0;
         busy  <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            mode_q[i] <= mode_d[i];
            half_q[i] <= half_d[i];
            cnt_q[i]  <= cnt_d[i];
         end
         LED   <= led_d;
         LED_N <= ~led_d;
         tick  <= tick_d;
         busy  <= busy_d;
      end
   end

endmodule
